min_queue_scheduler: RTL and testbench
======================================

Name: min_queue_scheduler

Overview:
- Sequencing controller between the min-queue top-level push/pop interface and ram_manager.
- Absorbs push bursts in a small internal input FIFO and drains it into ram_manager one record at a time.
- Issues pops to ram_manager only when its minimum is stable.
- Owns the full, push_wait, empty and min_valid flags and the total occupancy count.

Parameters:
- q_depth, 1024, maximum records held (RAM plus input FIFO).
- ptr_wd, 10, log2(q_depth); the occupancy counter is ptr_wd+1 bits.
- fifo_depth, 4, input FIFO entries (power of 2).
- fifo_ptr_wd, 2, log2(fifo_depth).
- rec_wd, 48, record width (6 bytes).

Ports:
- clk  in  1  single clock; all state on posedge.
- rst_b  in  1  asynchronous, active-low reset.
- push  in  1  push request; accepted when push & !full & !push_wait.
- push_record  in  rec_wd  record to push.
- full  out  1  registered; occupancy == q_depth.
- push_wait  out  1  registered; input FIFO full, or pop drain in progress.
- pop  in  1  pop request; accepted when pop & min_valid.
- pop_record  out  rec_wd  combinational passthrough of ram_min_record.
- empty  out  1  registered; occupancy == 0.
- min_valid  out  1  registered; pop_record is the true minimum this cycle.
- ram_push  out  1  one-cycle strobe: write ram_record into ram_manager.
- ram_record  out  rec_wd  registered record for ram_push.
- ram_pop  out  1  one-cycle strobe: remove current minimum.
- ram_busy  in  1  ram_manager reorganising; high from the cycle after a strobe until done.
- ram_min_record  in  rec_wd  current RAM minimum.
- ram_min_valid  in  1  ram_min_record is stable.

Behaviour:
- Reset (async, rst_b=0): full=0, push_wait=0, empty=1, min_valid=0, ram_push=0, ram_pop=0, ram_record=0. FIFO pointers, FIFO count, occupancy, pop_pend all 0; state=IDLE. Asserting reset mid-operation discards all FIFO contents and any in-flight command.
- Occupancy:
  - +1 on an accepted push, -1 on an accepted pop; both in one cycle leaves it unchanged.
  - Pushes while full are ignored and are not counted.
  - full and empty are registered from next-occupancy, so they are correct in the same cycle the count changes.
- Input FIFO:
  - Accepted push writes at wr_ptr. Pointers wrap modulo fifo_depth.
  - Head is dequeued only in IDLE when the drain condition holds (see FSM).
- pop_pend:
  - Set when pop=1 while min_valid=0 and occupancy != 0.
  - Cleared when a pop is accepted.
  - While set, push_wait is forced to 1 so the FIFO drains. This prevents pop starvation under continuous pushing.
- push_wait next-value = (fifo_count_next == fifo_depth) | pop_pend_next.
- min_valid next-value = (state_next == IDLE) & (fifo_count_next == 0) & ram_min_valid & !ram_busy & (occupancy_next != 0) & !ram_pop.
- FSM states:
  - IDLE:
    - Accepted pop → pulse ram_pop for 1 cycle, go to WAIT_RAM. Pop has priority over drain.
    - Else, if fifo_count != 0 and !ram_busy → load ram_record from the FIFO head, pulse ram_push, dequeue, go to WAIT_RAM.
    - Else remain in IDLE.
  - WAIT_RAM:
    - Stay at least one cycle, ignoring ram_busy in the first cycle.
    - Thereafter return to IDLE on the first cycle with ram_busy=0.
- Latency:
  - Push into an empty system: ram_push 1 cycle after acceptance.
  - min_valid returns after the first cycle of WAIT_RAM ends and ram_busy=0; minimum 3 cycles after push acceptance.
- Simultaneous push and pop in IDLE with an empty FIFO: pop goes to RAM, push enters the FIFO, occupancy unchanged, min_valid drops next cycle.
- Push when full=1 but push_wait=0: ignored, no state change.
- ram_push and ram_pop are never high together and never issued outside IDLE.

Test Plan:
- Reset then 3 back-to-back pushes of keys 0x30, 0x10, 0x20 (ram_busy held 2 cycles per command) → ram_push strobes 3 times in FIFO order; push_wait stays 0; min_valid=1 after the last drain with pop_record=0x10; empty=0.
- 5 pushes in 5 consecutive cycles with ram_busy held high → push_wait=1 after the 4th; 5th push ignored; occupancy=4.
- Pop asserted while the FIFO holds 2 records → pop_pend set, push_wait=1 until FIFO empty; then min_valid=1 and the pop is accepted; ram_pop pulses exactly once.
- q_depth overridden to 8; push 8 records → full=1 in the cycle after the 8th acceptance; 9th push ignored; one pop → full=0 next cycle.
- Push and pop in the same cycle with 1 record in RAM and min_valid=1 → ram_pop issued first, then the pushed record is drained; occupancy stays 1; empty never asserts.
- rst_b pulsed low asynchronously mid-WAIT_RAM with 3 FIFO entries → all outputs return to reset values immediately; no ram_push/ram_pop after release until a new push.

Source files
------------

// File: rtl/min_queue_scheduler.sv
// min_queue_scheduler: sequences min-queue pushes/pops into ram_manager through a small input FIFO
// Ports:
//   clk, rst_b                       clock, asynchronous active-low reset
//   push, push_record                push request and record (accepted when !full & !push_wait)
//   full, push_wait                  registered back-pressure flags
//   pop, pop_record                  pop request (accepted when min_valid) and current minimum
//   empty, min_valid                 registered occupancy / minimum-stable flags
//   ram_push, ram_record, ram_pop    one-cycle commands to ram_manager
//   ram_busy, ram_min_record, ram_min_valid   ram_manager status
module min_queue_scheduler #(
  parameter int q_depth = 1024,
  parameter int ptr_wd = 10,
  parameter int fifo_depth = 4,
  parameter int fifo_ptr_wd = 2,
  parameter int rec_wd = 48
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              push,
  input  logic [rec_wd-1:0] push_record,
  output logic              full,
  output logic              push_wait,
  input  logic              pop,
  output logic [rec_wd-1:0] pop_record,
  output logic              empty,
  output logic              min_valid,
  output logic              ram_push,
  output logic [rec_wd-1:0] ram_record,
  output logic              ram_pop,
  input  logic              ram_busy,
  input  logic [rec_wd-1:0] ram_min_record,
  input  logic              ram_min_valid
);
  // WAIT_FIRST is the first WAIT_RAM cycle, where ram_busy has not risen yet and is ignored
  typedef enum logic [1:0] {IDLE, WAIT_FIRST, WAIT_RAM} state_t;
  state_t state, state_next;
  logic [rec_wd-1:0] fifo_mem [fifo_depth];
  logic [fifo_ptr_wd-1:0] wr_ptr, rd_ptr;
  logic [fifo_ptr_wd:0] fifo_count, fifo_count_next;
  logic [ptr_wd:0] occ, occ_next;
  logic pop_pend, pop_pend_next;
  logic push_acc, pop_acc, drain, ram_pop_next, min_valid_next;
  assign push_acc = push & ~full & ~push_wait;
  assign pop_acc = pop & min_valid;
  assign pop_record = ram_min_record;
  assign ram_pop_next = (state == IDLE) & pop_acc;
  // pop wins over draining the FIFO head
  assign drain = (state == IDLE) & ~pop_acc & (fifo_count != '0) & ~ram_busy;
  assign fifo_count_next = fifo_count + (fifo_ptr_wd+1)'(push_acc) - (fifo_ptr_wd+1)'(drain);
  assign occ_next = occ + (ptr_wd+1)'(push_acc) - (ptr_wd+1)'(pop_acc);
  // a blocked pop holds off new pushes so the FIFO can drain and the minimum settle
  assign pop_pend_next = pop_acc ? 1'b0 : (pop & ~min_valid & (occ != '0)) ? 1'b1 : pop_pend;
  assign min_valid_next = (state_next == IDLE) & (fifo_count_next == '0) & ram_min_valid &
                          ~ram_busy & (occ_next != '0) & ~ram_pop;
  always_comb begin
    state_next = state;
    case (state)
      IDLE:       state_next = (ram_pop_next | drain) ? WAIT_FIRST : IDLE;
      WAIT_FIRST: state_next = WAIT_RAM;
      default:    state_next = ram_busy ? WAIT_RAM : IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      occ        <= '0;
      pop_pend   <= 1'b0;
      full       <= 1'b0;
      push_wait  <= 1'b0;
      empty      <= 1'b1;
      min_valid  <= 1'b0;
      ram_push   <= 1'b0;
      ram_pop    <= 1'b0;
      ram_record <= '0;
    end else begin
      state      <= state_next;
      wr_ptr     <= wr_ptr + fifo_ptr_wd'(push_acc);
      rd_ptr     <= rd_ptr + fifo_ptr_wd'(drain);
      fifo_count <= fifo_count_next;
      occ        <= occ_next;
      pop_pend   <= pop_pend_next;
      full       <= occ_next == (ptr_wd+1)'(q_depth);
      push_wait  <= (fifo_count_next == (fifo_ptr_wd+1)'(fifo_depth)) | pop_pend_next;
      empty      <= occ_next == '0;
      min_valid  <= min_valid_next;
      ram_push   <= drain;
      ram_pop    <= ram_pop_next;
      ram_record <= drain ? fifo_mem[rd_ptr] : ram_record;
    end
  end
  always_ff @(posedge clk) begin
    if (push_acc) fifo_mem[wr_ptr] <= push_record;
  end
endmodule

// File: tb/tb_min_queue_scheduler.sv
// tb_min_queue_scheduler: directed tests of min_queue_scheduler against a sorted-list ram_manager model
module tb_min_queue_scheduler;
  localparam int RW = 48;
  logic clk = 1'b0, rst_b = 1'b0, push = 1'b0, pop = 1'b0, hold_busy = 1'b0;
  logic [RW-1:0] push_record = '0;
  logic full, push_wait, empty, min_valid, ram_push, ram_pop, ram_busy, ram_min_valid;
  logic [RW-1:0] pop_record, ram_record, ram_min_record;
  int errors = 0, checks = 0, busy_len = 2;
  int bcnt = 0, ram_n = 0;
  logic [RW-1:0] ram_min = '0;
  logic [RW-1:0] ram_q[$];
  int cyc = 0, n_push = 0, n_pop = 0, t_push = 0, t_pop = 0;
  logic both_seen = 1'b0;
  logic [RW-1:0] push_log[$];

  always #5 clk = ~clk;

  min_queue_scheduler #(.q_depth(8), .ptr_wd(3), .fifo_depth(4), .fifo_ptr_wd(2), .rec_wd(RW)) dut (
    .clk(clk), .rst_b(rst_b), .push(push), .push_record(push_record), .full(full),
    .push_wait(push_wait), .pop(pop), .pop_record(pop_record), .empty(empty),
    .min_valid(min_valid), .ram_push(ram_push), .ram_record(ram_record), .ram_pop(ram_pop),
    .ram_busy(ram_busy), .ram_min_record(ram_min_record), .ram_min_valid(ram_min_valid)
  );

  assign ram_busy = hold_busy | (bcnt != 0);
  assign ram_min_valid = ~ram_busy & (ram_n != 0);
  assign ram_min_record = ram_min;

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ram_q.delete();
      bcnt <= 0;
      ram_n <= 0;
      ram_min <= '0;
    end else begin
      if (ram_push) begin
        int i;
        i = 0;
        while (i < ram_q.size() && ram_q[i] <= ram_record) i++;
        ram_q.insert(i, ram_record);
      end
      if (ram_pop && ram_q.size() != 0) ram_q.delete(0);
      bcnt <= (ram_push | ram_pop) ? busy_len : (bcnt != 0 ? bcnt - 1 : 0);
      ram_n <= ram_q.size();
      ram_min <= (ram_q.size() != 0) ? ram_q[0] : '0;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_push) begin n_push <= n_push + 1; t_push <= cyc; push_log.push_back(ram_record); end
    if (ram_pop) begin n_pop <= n_pop + 1; t_pop <= cyc; end
    if (ram_push & ram_pop) both_seen <= 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    push = 1'b0; pop = 1'b0; hold_busy = 1'b0; busy_len = 2; rst_b = 1'b0;
    tick(); tick();
    rst_b = 1'b1;
    tick();
  endtask

  task automatic wait_mv(input string name);
    int k = 0;
    while (min_valid !== 1'b1 && k < 200) begin tick(); k++; end
    checks++;
    if (min_valid !== 1'b1) begin errors++; $display("FAIL %s min_valid timeout: got %b want 1", name, min_valid); end
  endtask

  task automatic push_one(input logic [RW-1:0] v);
    int k = 0;
    while ((push_wait | full) !== 1'b0 && k < 200) begin tick(); k++; end
    checks++;
    if ((push_wait | full) !== 1'b0) begin errors++; $display("FAIL push_one blocked: got wait|full=%b want 0", push_wait | full); end
    push = 1'b1; push_record = v;
    tick();
    push = 1'b0;
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    tick();
    checks += 7;
    if (full !== 1'b0) begin errors++; $display("FAIL reset full: got %b want 0", full); end
    if (push_wait !== 1'b0) begin errors++; $display("FAIL reset push_wait: got %b want 0", push_wait); end
    if (empty !== 1'b1) begin errors++; $display("FAIL reset empty: got %b want 1", empty); end
    if (min_valid !== 1'b0) begin errors++; $display("FAIL reset min_valid: got %b want 0", min_valid); end
    if (ram_push !== 1'b0) begin errors++; $display("FAIL reset ram_push: got %b want 0", ram_push); end
    if (ram_pop !== 1'b0) begin errors++; $display("FAIL reset ram_pop: got %b want 0", ram_pop); end
    if (ram_record !== '0) begin errors++; $display("FAIL reset ram_record: got %h want 0", ram_record); end
    rst_b = 1'b1;
    tick(); tick();
    checks += 2;
    if (empty !== 1'b1) begin errors++; $display("FAIL idle empty: got %b want 1", empty); end
    if (ram_push !== 1'b0) begin errors++; $display("FAIL idle ram_push: got %b want 0", ram_push); end
  endtask

  task automatic test_back_to_back();
    int b = push_log.size();
    int np = n_push;
    logic pw = 1'b0;
    logic [RW-1:0] keys [3] = '{48'h30, 48'h10, 48'h20};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push = 1'b1; push_record = keys[i];
      tick();
      pw |= push_wait;
    end
    push = 1'b0;
    wait_mv("b2b");
    checks += 5;
    if (n_push - np !== 3) begin errors++; $display("FAIL b2b strobes: got %0d want 3", n_push - np); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (push_log[b+i] !== keys[i]) begin errors++; $display("FAIL b2b order %0d: got %h want %h", i, push_log[b+i], keys[i]); end
    end
    if (pw !== 1'b0) begin errors++; $display("FAIL b2b push_wait: got %b want 0", pw); end
    if (push_wait !== 1'b0) begin errors++; $display("FAIL b2b push_wait end: got %b want 0", push_wait); end
    if (pop_record !== 48'h10) begin errors++; $display("FAIL b2b pop_record: got %h want 10", pop_record); end
    if (empty !== 1'b0) begin errors++; $display("FAIL b2b empty: got %b want 0", empty); end
  endtask

  task automatic test_fifo_full();
    int np = n_push;
    logic [RW-1:0] v;
    logic [RW-1:0] keys [5] = '{48'h50, 48'h40, 48'h60, 48'h45, 48'h99};
    logic [RW-1:0] exp [4] = '{48'h40, 48'h45, 48'h50, 48'h60};
    do_reset();
    hold_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push = 1'b1; push_record = keys[i];
      tick();
      if (i == 2) begin
        checks++;
        if (push_wait !== 1'b0) begin errors++; $display("FAIL ff push_wait after 3rd: got %b want 0", push_wait); end
      end
      if (i == 3) begin
        checks++;
        if (push_wait !== 1'b1) begin errors++; $display("FAIL ff push_wait after 4th: got %b want 1", push_wait); end
      end
    end
    push = 1'b0;
    checks += 2;
    if (n_push - np !== 0) begin errors++; $display("FAIL ff drained while busy: got %0d want 0", n_push - np); end
    if (empty !== 1'b0) begin errors++; $display("FAIL ff empty: got %b want 0", empty); end
    hold_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_mv("ff pop");
      pop = 1'b1; v = pop_record;
      tick();
      pop = 1'b0;
      checks += 2;
      if (v !== exp[i]) begin errors++; $display("FAIL ff pop %0d: got %h want %h", i, v, exp[i]); end
      if (empty !== (i == 3)) begin errors++; $display("FAIL ff empty after pop %0d: got %b want %b", i, empty, i == 3); end
    end
    repeat (10) tick();
    checks += 2;
    if (n_push - np !== 4) begin errors++; $display("FAIL ff 5th drained: got %0d want 4", n_push - np); end
    if (min_valid !== 1'b0) begin errors++; $display("FAIL ff min_valid empty: got %b want 0", min_valid); end
  endtask

  task automatic test_pop_pend();
    int np = n_pop;
    int k = 0;
    logic pw_ok = 1'b1;
    logic [RW-1:0] v;
    do_reset();
    hold_busy = 1'b1;
    push_one(48'h22);
    push_one(48'h11);
    pop = 1'b1;
    tick();
    checks++;
    if (push_wait !== 1'b1) begin errors++; $display("FAIL pend push_wait set: got %b want 1", push_wait); end
    hold_busy = 1'b0;
    while (min_valid !== 1'b1 && k < 200) begin
      if (push_wait !== 1'b1) pw_ok = 1'b0;
      tick();
      k++;
    end
    checks += 3;
    if (min_valid !== 1'b1) begin errors++; $display("FAIL pend min_valid timeout: got %b want 1", min_valid); end
    if (pw_ok !== 1'b1) begin errors++; $display("FAIL pend push_wait held: got %b want 1", pw_ok); end
    if (push_wait !== 1'b1) begin errors++; $display("FAIL pend push_wait at accept: got %b want 1", push_wait); end
    v = pop_record;
    tick();
    pop = 1'b0;
    checks += 3;
    if (v !== 48'h11) begin errors++; $display("FAIL pend popped: got %h want 11", v); end
    if (ram_pop !== 1'b1) begin errors++; $display("FAIL pend ram_pop: got %b want 1", ram_pop); end
    if (push_wait !== 1'b0) begin errors++; $display("FAIL pend push_wait clear: got %b want 0", push_wait); end
    repeat (10) tick();
    checks++;
    if (n_pop - np !== 1) begin errors++; $display("FAIL pend ram_pop count: got %0d want 1", n_pop - np); end
    wait_mv("pend rest");
    checks += 2;
    if (pop_record !== 48'h22) begin errors++; $display("FAIL pend remaining: got %h want 22", pop_record); end
    if (empty !== 1'b0) begin errors++; $display("FAIL pend empty: got %b want 0", empty); end
  endtask

  task automatic test_full();
    int np = n_push;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      push_one(48'h107 - 48'(i));
      if (i == 6) begin
        checks++;
        if (full !== 1'b0) begin errors++; $display("FAIL full after 7: got %b want 0", full); end
      end
    end
    checks++;
    if (full !== 1'b1) begin errors++; $display("FAIL full after 8: got %b want 1", full); end
    wait_mv("full");
    checks += 2;
    if (full !== 1'b1) begin errors++; $display("FAIL full held: got %b want 1", full); end
    if (push_wait !== 1'b0) begin errors++; $display("FAIL full push_wait: got %b want 0", push_wait); end
    push = 1'b1; push_record = 48'h1;
    tick();
    push = 1'b0;
    repeat (6) tick();
    checks += 4;
    if (min_valid !== 1'b1) begin errors++; $display("FAIL full 9th min_valid: got %b want 1", min_valid); end
    if (n_push - np !== 8) begin errors++; $display("FAIL full 9th strobes: got %0d want 8", n_push - np); end
    if (pop_record !== 48'h100) begin errors++; $display("FAIL full 9th min: got %h want 100", pop_record); end
    if (full !== 1'b1) begin errors++; $display("FAIL full 9th full: got %b want 1", full); end
    pop = 1'b1;
    tick();
    pop = 1'b0;
    checks++;
    if (full !== 1'b0) begin errors++; $display("FAIL full after pop: got %b want 0", full); end
  endtask

  task automatic test_push_pop_same();
    int np, npp;
    int k = 0;
    logic e_seen = 1'b0;
    do_reset();
    push_one(48'h70);
    wait_mv("same setup");
    np = n_push; npp = n_pop;
    push = 1'b1; push_record = 48'h05; pop = 1'b1;
    tick();
    push = 1'b0; pop = 1'b0;
    checks += 4;
    if (ram_pop !== 1'b1) begin errors++; $display("FAIL same ram_pop: got %b want 1", ram_pop); end
    if (ram_push !== 1'b0) begin errors++; $display("FAIL same ram_push: got %b want 0", ram_push); end
    if (min_valid !== 1'b0) begin errors++; $display("FAIL same min_valid drop: got %b want 0", min_valid); end
    if (empty !== 1'b0) begin errors++; $display("FAIL same empty: got %b want 0", empty); end
    while (min_valid !== 1'b1 && k < 200) begin tick(); k++; e_seen |= empty; end
    checks += 6;
    if (min_valid !== 1'b1) begin errors++; $display("FAIL same min_valid timeout: got %b want 1", min_valid); end
    if (e_seen !== 1'b0) begin errors++; $display("FAIL same empty seen: got %b want 0", e_seen); end
    if (pop_record !== 48'h05) begin errors++; $display("FAIL same min: got %h want 05", pop_record); end
    if (n_pop - npp !== 1) begin errors++; $display("FAIL same pops: got %0d want 1", n_pop - npp); end
    if (n_push - np !== 1) begin errors++; $display("FAIL same pushes: got %0d want 1", n_push - np); end
    if (!(t_pop < t_push)) begin errors++; $display("FAIL same order: got pop@%0d push@%0d want pop first", t_pop, t_push); end
  endtask

  task automatic test_async_reset();
    int np, npp;
    do_reset();
    busy_len = 5;
    for (int i = 0; i < 4; i++) begin
      push = 1'b1; push_record = 48'hA1 + 48'(i);
      tick();
    end
    push = 1'b0;
    checks += 2;
    if (ram_record !== 48'hA1) begin errors++; $display("FAIL arst pre ram_record: got %h want a1", ram_record); end
    if (empty !== 1'b0) begin errors++; $display("FAIL arst pre empty: got %b want 0", empty); end
    np = n_push; npp = n_pop;
    #2 rst_b = 1'b0;
    #1;
    checks += 7;
    if (full !== 1'b0) begin errors++; $display("FAIL arst full: got %b want 0", full); end
    if (push_wait !== 1'b0) begin errors++; $display("FAIL arst push_wait: got %b want 0", push_wait); end
    if (empty !== 1'b1) begin errors++; $display("FAIL arst empty: got %b want 1", empty); end
    if (min_valid !== 1'b0) begin errors++; $display("FAIL arst min_valid: got %b want 0", min_valid); end
    if (ram_push !== 1'b0) begin errors++; $display("FAIL arst ram_push: got %b want 0", ram_push); end
    if (ram_pop !== 1'b0) begin errors++; $display("FAIL arst ram_pop: got %b want 0", ram_pop); end
    if (ram_record !== '0) begin errors++; $display("FAIL arst ram_record: got %h want 0", ram_record); end
    #2 rst_b = 1'b1;
    busy_len = 2;
    repeat (10) tick();
    checks += 3;
    if (n_push !== np) begin errors++; $display("FAIL arst stray ram_push: got %0d want %0d", n_push, np); end
    if (n_pop !== npp) begin errors++; $display("FAIL arst stray ram_pop: got %0d want %0d", n_pop, npp); end
    if (empty !== 1'b1) begin errors++; $display("FAIL arst idle empty: got %b want 1", empty); end
    push_one(48'hB7);
    wait_mv("arst new");
    checks += 3;
    if (pop_record !== 48'hB7) begin errors++; $display("FAIL arst new min: got %h want b7", pop_record); end
    if (ram_record !== 48'hB7) begin errors++; $display("FAIL arst new ram_record: got %h want b7", ram_record); end
    if (n_push - np !== 1) begin errors++; $display("FAIL arst new strobes: got %0d want 1", n_push - np); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_fifo_full();
    test_pop_pend();
    test_full();
    test_push_pop_same();
    test_async_reset();
    checks++;
    if (both_seen !== 1'b0) begin errors++; $display("FAIL strobe overlap: got %b want 0", both_seen); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
